// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and
// registers the fetched word into IF/ID; handles stall, redirect and halt.
module fetch_stage #(
  parameter int          ADDR_W     = 5,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_instr,
  output logic [31:0]       if_id_pc,
  output logic [31:0]       if_id_pc4,
  output logic [31:0]       if_id_instr,
  output logic              if_id_valid,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt, w_pc_plus4;
  logic [31:0] r_ifid_pc, r_ifid_pc4, r_ifid_instr;
  logic [31:0] w_ifid_pc_nxt, w_ifid_pc4_nxt, w_ifid_instr_nxt;
  logic        r_ifid_valid, w_ifid_valid_nxt;
  logic [31:0] r_fetch_count, w_fetch_count_nxt;

  assign w_pc_plus4 = r_pc + 32'd4;
  // Only the word-index bits reach the ROM, so fetch wraps every 2^ADDR_W words.
  assign rom_addr   = r_pc[ADDR_W+1:2];

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_ifid_pc_nxt     = r_ifid_pc;
    w_ifid_pc4_nxt    = r_ifid_pc4;
    w_ifid_instr_nxt  = r_ifid_instr;
    w_ifid_valid_nxt  = r_ifid_valid;
    w_fetch_count_nxt = r_fetch_count;
    if (redirect) begin
      // A halt seen on the wrong path is discarded by the redirect.
      w_pc_nxt         = redirect_pc & ~32'd3;
      w_ifid_instr_nxt = NOP_INSTR;
      w_ifid_valid_nxt = 1'b0;
      w_state_nxt      = RUN;
    end else if (!stall) begin
      if (r_state == RUN) begin
        w_ifid_pc_nxt     = r_pc;
        w_ifid_pc4_nxt    = w_pc_plus4;
        w_ifid_instr_nxt  = rom_instr;
        w_ifid_valid_nxt  = 1'b1;
        w_fetch_count_nxt = r_fetch_count + 32'd1;
        if (rom_instr == HALT_INSTR) begin
          w_state_nxt = HALTED;
        end else begin
          w_pc_nxt = w_pc_plus4;
        end
      end else begin
        w_ifid_instr_nxt = NOP_INSTR;
        w_ifid_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_pc          <= RESET_PC;
      r_ifid_pc     <= 32'd0;
      r_ifid_pc4    <= 32'd0;
      r_ifid_instr  <= NOP_INSTR;
      r_ifid_valid  <= 1'b0;
      r_fetch_count <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_ifid_pc     <= w_ifid_pc_nxt;
      r_ifid_pc4    <= w_ifid_pc4_nxt;
      r_ifid_instr  <= w_ifid_instr_nxt;
      r_ifid_valid  <= w_ifid_valid_nxt;
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  assign if_id_pc    = r_ifid_pc;
  assign if_id_pc4   = r_ifid_pc4;
  assign if_id_instr = r_ifid_instr;
  assign if_id_valid = r_ifid_valid;
  assign halted      = (r_state == HALTED);
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run checked
// against a rule-level model of the fetch stage.
module tb_fetch_stage;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect;
  logic [31:0] redirect_pc, rom_instr;
  logic [4:0]  rom_addr;
  logic [31:0] if_id_pc, if_id_pc4, if_id_instr, fetch_count;
  logic        if_id_valid, halted;

  logic [31:0] rom [32];
  assign rom_instr = rom[rom_addr];

  // Reference model state: what each output should hold after the next edge.
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt;
  logic        m_valid, m_halted;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .rom_addr(rom_addr), .rom_instr(rom_instr),
    .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Advance one clock; the model applies the fetch rules to the same inputs.
  task automatic step();
    logic [31:0] w;
    if (!rst_n) begin
      m_pc = 32'd0; m_ipc = 32'd0; m_ipc4 = 32'd0; m_instr = NOP;
      m_valid = 1'b0; m_halted = 1'b0; m_cnt = 32'd0;
    end else if (redirect) begin
      m_pc = {redirect_pc[31:2], 2'b00}; m_instr = NOP; m_valid = 1'b0; m_halted = 1'b0;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (m_halted) begin
      m_instr = NOP; m_valid = 1'b0;
    end else begin
      w = rom[m_pc[6:2]];
      m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = w; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
      if (w == HALT) m_halted = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rom(input int halt_pct);
    for (int i = 0; i < 32; i++)
      rom[i] = ($urandom_range(99) < halt_pct) ? HALT : ($urandom() & 32'hFFFF_FFFE);
  endtask

  task automatic test_reset();
    fill_rom(0);
    rom[0] = 32'h0050_0513; rom[1] = 32'h00C0_00EF; rom[3] = HALT; rom[4] = 32'hFF81_0113;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    step(); step();
    n_tests++; if (rom_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rom_addr got %0h want 0", rom_addr); end
    n_tests++; if ({if_id_pc, if_id_pc4} !== 64'd0) begin n_fail++; $display("FAIL reset_pc_fields got %h/%h want 0/0", if_id_pc, if_id_pc4); end
    n_tests++; if (if_id_instr !== NOP || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ifid got %h v%b want %h v0", if_id_instr, if_id_valid, NOP); end
    n_tests++; if (halted !== 1'b0 || fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl got h%b cnt %0d want h0 cnt 0", halted, fetch_count); end
  endtask

  task automatic test_freerun();
    rst_n = 1'b1;
    n_tests++; if (rom_addr !== 5'd0) begin n_fail++; $display("FAIL run_first_addr got %0d want 0", rom_addr); end
    step();
    n_tests++; if ({if_id_pc, if_id_pc4, if_id_instr, if_id_valid} !== {32'd0, 32'd4, 32'h0050_0513, 1'b1})
      begin n_fail++; $display("FAIL run_first_ifid got %h %h %h %b want 0 4 00500513 1", if_id_pc, if_id_pc4, if_id_instr, if_id_valid); end
    n_tests++; if (rom_addr !== 5'd1 || fetch_count !== 32'd1) begin n_fail++; $display("FAIL run_first_state got addr %0d cnt %0d want 1 1", rom_addr, fetch_count); end
  endtask

  task automatic test_redirect();
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0013;
    step();
    redirect = 1'b0;
    n_tests++; if (rom_addr !== 5'd4) begin n_fail++; $display("FAIL redir_addr got %0d want 4", rom_addr); end
    n_tests++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'd4)
      begin n_fail++; $display("FAIL redir_bubble got v%b %h pc %h want v0 %h pc 4", if_id_valid, if_id_instr, if_id_pc, NOP); end
    step();
    n_tests++; if (if_id_pc !== 32'h10 || if_id_instr !== 32'hFF81_0113)
      begin n_fail++; $display("FAIL redir_target got %h %h want 10 ff810113", if_id_pc, if_id_instr); end
  endtask

  task automatic test_stall();
    logic [31:0] s_pc, s_instr, s_cnt;
    logic        s_valid;
    redirect = 1'b1; redirect_pc = 32'h24;
    step();
    redirect = 1'b0;
    s_pc = if_id_pc; s_instr = if_id_instr; s_cnt = fetch_count; s_valid = if_id_valid;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if ({rom_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count} !== {5'd9, s_pc, s_instr, s_valid, s_cnt})
        begin n_fail++; $display("FAIL stall_hold%0d got %0d %h %h %b %0d want 9 %h %h %b %0d", i, rom_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count, s_pc, s_instr, s_valid, s_cnt); end
    end
    stall = 1'b0;
    step();
    n_tests++; if (if_id_pc !== 32'h24 || if_id_instr !== rom[9] || fetch_count !== s_cnt + 32'd1)
      begin n_fail++; $display("FAIL stall_release got %h %h %0d want 24 %h %0d", if_id_pc, if_id_instr, fetch_count, rom[9], s_cnt + 1); end
  endtask

  task automatic test_halt();
    logic [31:0] c0;
    redirect = 1'b1; redirect_pc = 32'h8;
    step();
    redirect = 1'b0;
    step(); step();
    c0 = fetch_count;
    n_tests++; if ({if_id_instr, if_id_valid, halted, rom_addr, if_id_pc} !== {HALT, 1'b1, 1'b1, 5'd3, 32'hC})
      begin n_fail++; $display("FAIL halt_capture got %h v%b h%b addr %0d pc %h want ffffffff 1 1 3 c", if_id_instr, if_id_valid, halted, rom_addr, if_id_pc); end
    step();
    n_tests++; if ({if_id_instr, if_id_valid, halted, rom_addr, fetch_count} !== {NOP, 1'b0, 1'b1, 5'd3, c0})
      begin n_fail++; $display("FAIL halt_frozen got %h v%b h%b addr %0d cnt %0d want %h 0 1 3 %0d", if_id_instr, if_id_valid, halted, rom_addr, fetch_count, NOP, c0); end
    redirect = 1'b1; redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    n_tests++; if (halted !== 1'b0 || rom_addr !== 5'd4) begin n_fail++; $display("FAIL halt_redirect got h%b addr %0d want 0 4", halted, rom_addr); end
    step();
    n_tests++; if (if_id_pc !== 32'h10 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL halt_resume got %h v%b want 10 1", if_id_pc, if_id_valid); end
    // Halt word presented under stall must wait for the stall to release.
    redirect = 1'b1; redirect_pc = 32'hC;
    step();
    redirect = 1'b0; stall = 1'b1;
    step();
    n_tests++; if (halted !== 1'b0 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL halt_stalled got h%b v%b want 0 0", halted, if_id_valid); end
    stall = 1'b0;
    step();
    n_tests++; if (halted !== 1'b1 || if_id_instr !== HALT) begin n_fail++; $display("FAIL halt_after_stall got h%b %h want 1 ffffffff", halted, if_id_instr); end
  endtask

  task automatic test_redirect_halt();
    redirect = 1'b1; redirect_pc = 32'hC;
    step();
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    n_tests++; if ({halted, rom_addr, if_id_valid, if_id_instr} !== {1'b0, 5'd16, 1'b0, NOP})
      begin n_fail++; $display("FAIL redir_on_halt got h%b addr %0d v%b %h want 0 16 0 %h", halted, rom_addr, if_id_valid, if_id_instr, NOP); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'h7C;
    step();
    redirect = 1'b0;
    n_tests++; if (rom_addr !== 5'd31) begin n_fail++; $display("FAIL wrap_addr31 got %0d want 31", rom_addr); end
    step();
    n_tests++; if (if_id_pc !== 32'h7C || rom_addr !== 5'd0) begin n_fail++; $display("FAIL wrap_first got %h addr %0d want 7c 0", if_id_pc, rom_addr); end
    step();
    n_tests++; if (if_id_pc !== 32'h80 || if_id_pc4 !== 32'h84 || if_id_instr !== rom[0])
      begin n_fail++; $display("FAIL wrap_second got %h %h %h want 80 84 %h", if_id_pc, if_id_pc4, if_id_instr, rom[0]); end
    rst_n = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    step();
    n_tests++; if ({rom_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, halted, fetch_count} !== {5'd0, 32'd0, 32'd0, NOP, 1'b0, 1'b0, 32'd0})
      begin n_fail++; $display("FAIL midrun_reset got %0d %h %h %h %b %b %0d want all reset values", rom_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, halted, fetch_count); end
    rst_n = 1'b1; stall = 1'b0; redirect = 1'b0;
  endtask

  task automatic test_random();
    fill_rom(10);
    rom[0] = 32'h0050_0513;
    for (int i = 0; i < 600; i++) begin
      rst_n       = ($urandom_range(99) >= 2);
      stall       = ($urandom_range(99) < 25);
      redirect    = ($urandom_range(99) < 12);
      redirect_pc = $urandom();
      step();
      n_tests++;
      if ({rom_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, halted, fetch_count} !==
          {m_pc[6:2], m_ipc, m_ipc4, m_instr, m_valid, m_halted, m_cnt}) begin
        n_fail++;
        $display("FAIL random_cycle%0d got %0d %h %h %h %b %b %0d want %0d %h %h %h %b %b %0d", i,
                 rom_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, halted, fetch_count,
                 m_pc[6:2], m_ipc, m_ipc4, m_instr, m_valid, m_halted, m_cnt);
      end
    end
    rst_n = 1'b1; stall = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_freerun();
    test_redirect();
    test_stall();
    test_halt();
    test_redirect_halt();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RV32 pipelined CPU. Holds the program counter, drives the word address of the combinational instruction ROM, and registers the returned word into the IF/ID pipeline register. Accepts stall from hazard detection and PC redirects from branch/jump resolution. Detects the halt word (0xFFFFFFFF) and freezes fetch.

## Interface
- ADDR_W, 5, ROM word-address width (ROM depth 2^ADDR_W words)
- RESET_PC, 32'h0000_0000, byte address fetched first after reset
- HALT_INSTR, 32'hFFFF_FFFF, encoding that halts fetch
- NOP_INSTR, 32'h0000_0013, bubble inserted on flush/halt (addi x0,x0,0)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  hold PC and IF/ID contents
- redirect  in  1  take redirect_pc next cycle, flush IF/ID
- redirect_pc  in  32  target byte address (from EX: branch/jal/jalr)
- rom_addr  out  ADDR_W  word address to ROM, = pc[ADDR_W+1:2]
- rom_instr  in  32  ROM data, combinational from rom_addr
- if_id_pc  out  32  PC of the registered instruction
- if_id_pc4  out  32  if_id_pc + 4 (link value for jal/jalr)
- if_id_instr  out  32  registered instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- halted  out  1  fetch frozen on halt word
- fetch_count  out  32  number of valid instructions delivered to IF/ID

## Operation
- States: RUN, HALTED. Priority each cycle: reset > redirect > stall > normal.
- Reset (rst_n=0 at edge): pc=RESET_PC, state RUN, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc4=0, if_id_valid=0, halted=0, fetch_count=0.
- redirect=1 (either state): pc <= {redirect_pc[31:2],2'b00} (low bits ignored); IF/ID <= NOP_INSTR, valid 0, pc/pc4 fields unchanged; state <= RUN; halted <= 0. Redirect out of HALTED is legal (halt was wrong-path).
- stall=1, no redirect: pc, IF/ID, state, fetch_count all hold.
- RUN, normal, rom_instr != HALT_INSTR: IF/ID <= {pc, pc+4, rom_instr, valid 1}; pc <= pc+4; fetch_count += 1.
- RUN, normal, rom_instr == HALT_INSTR: IF/ID <= {pc, pc+4, HALT_INSTR, valid 1}; pc holds; fetch_count += 1; state <= HALTED; halted <= 1.
- HALTED, no redirect, no stall: pc holds; IF/ID <= NOP_INSTR, valid 0.
- Halt word under stall is not acted on until the stall releases (it is re-presented by the ROM).
- PC arithmetic is 32-bit modulo 2^32; rom_addr takes only pc[ADDR_W+1:2], so fetch wraps every 2^ADDR_W words (0x7C -> 0x80 reads word 0). Upper PC bits are retained in if_id_pc.
- fetch_count wraps at 2^32.

## Timing
- rom_addr is combinational from the pc register; the ROM is combinational, so an instruction is fetched and captured in the same cycle: latency pc -> IF/ID = 1 clock.
- All outputs except rom_addr are registered; all change only at rising clk.
- Redirect asserted in cycle n: cycle n+1 rom_addr = redirect target, IF/ID bubble; target instruction in IF/ID at end of n+1 (visible n+2). Redirect penalty beyond the flushed slot: 0 cycles.
- halted rises the cycle after the halt word is captured, together with if_id_instr=HALT_INSTR.
- Redirect and stall in the same cycle: redirect wins, stall ignored.
- Redirect in the same cycle the halt word is on rom_instr: no halt, state stays RUN.
- rst_n low mid-operation overrides stall/redirect; values above apply at the next edge.

## Test plan
- Reset then free-run with ROM word0=0x00500513, word1=0x00C000EF: cycle after reset release rom_addr=0; next edge IF/ID={pc 0, pc4 4, 0x00500513, valid 1}, rom_addr=1, fetch_count=1.
- Redirect to 0x10 while pc=0x8: next cycle rom_addr=4, if_id_valid=0, if_id_instr=0x00000013; following edge if_id_pc=0x10, if_id_instr=0xFF810113.
- Stall held 3 cycles at pc=0x24: rom_addr stays 9, IF/ID and fetch_count unchanged; release resumes with pc 0x24 captured.
- Halt at word 3 (pc 0xC), no redirect: if_id_instr=0xFFFFFFFF valid 1, halted=1, pc stays 0xC, subsequent IF/ID NOP valid 0; redirect to 0x10 afterwards clears halted, fetch resumes at word 4.
- Halt word on rom_instr same cycle as redirect to 0x40: halted stays 0, next rom_addr=16, IF/ID bubble.
- Wrap: redirect to 0x7C, run 2 cycles: rom_addr 31 then 0, if_id_pc 0x7C then 0x80; rst_n low mid-run returns all outputs to reset values at the next edge.
